// File: rtl/iob_nesctrl_pad_if.sv
// Signal bundle between the SoC/console side (master) and the NES pad emulator (slave).
interface iob_nesctrl_pad_if #(
  parameter int N_BITS = 8
) ();
  localparam int CW = $clog2(N_BITS + 1);

  logic              en;
  logic [N_BITS-1:0] buttons;
  logic              pad_latch_i;
  logic              pad_clk_i;
  logic              pad_data_o;
  logic [CW-1:0]     shift_cnt;
  logic              frame_done;
  logic              frame_abort;
  logic [15:0]       frame_cnt;

  modport master (
    output en, buttons, pad_latch_i, pad_clk_i,
    input  pad_data_o, shift_cnt, frame_done, frame_abort, frame_cnt
  );

  modport slave (
    input  en, buttons, pad_latch_i, pad_clk_i,
    output pad_data_o, shift_cnt, frame_done, frame_abort, frame_cnt
  );
endinterface

// File: rtl/iob_nesctrl_pad.sv
// NES controller device-side emulation: synchronizes the console latch/clock, loads the
// inverted button vector and shifts it out bit 0 first on the active-low data line.
module iob_nesctrl_pad #(
  parameter int   N_BITS   = 8,
  parameter logic FILL_VAL = 1'b0
) (
  input logic              clk,
  input logic              rst,
  iob_nesctrl_pad_if.slave bus
);
  localparam int            CW      = $clog2(N_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_BITS);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            r_state;
  logic [1:0]        r_latch_sync;
  logic [1:0]        r_clk_sync;
  logic              r_clk_d;
  logic [N_BITS-1:0] r_sr;
  logic [CW-1:0]     r_shift_cnt;
  logic [15:0]       r_frame_cnt;
  logic              r_frame_done;
  logic              r_frame_abort;

  logic              w_latch_s;
  logic              w_clk_s;
  logic              w_clk_rise;
  logic [N_BITS-1:0] w_sr_shifted;
  logic [CW-1:0]     w_cnt_inc;

  assign w_latch_s    = r_latch_sync[1];
  assign w_clk_s      = r_clk_sync[1];
  assign w_clk_rise   = w_clk_s & ~r_clk_d;
  assign w_sr_shifted = {FILL_VAL, r_sr[N_BITS-1:1]};
  assign w_cnt_inc    = r_shift_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_latch_sync  <= '0;
      r_clk_sync    <= '0;
      r_clk_d       <= 1'b0;
      r_state       <= IDLE;
      r_sr          <= '1;
      r_shift_cnt   <= '0;
      r_frame_cnt   <= '0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_latch_sync  <= {r_latch_sync[0], bus.pad_latch_i};
      r_clk_sync    <= {r_clk_sync[0], bus.pad_clk_i};
      r_clk_d       <= w_clk_s;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      if (!bus.en) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_latch_s) r_state <= LOAD;
          end
          LOAD: begin
            // Transparent while latched; the value seen on the last latched cycle is kept.
            if (!w_latch_s) begin
              r_state <= SHIFT;
            end else begin
              r_sr        <= ~bus.buttons;
              r_shift_cnt <= '0;
            end
          end
          SHIFT: begin
            if (w_latch_s) begin
              r_state       <= LOAD;
              r_frame_abort <= (r_shift_cnt != '0);
            end else if (w_clk_rise) begin
              r_sr        <= w_sr_shifted;
              r_shift_cnt <= w_cnt_inc;
              if (w_cnt_inc == CNT_MAX) begin
                r_state      <= DONE;
                r_frame_done <= 1'b1;
                r_frame_cnt  <= r_frame_cnt + 16'd1;
              end
            end
          end
          DONE: begin
            if (w_latch_s) r_state <= LOAD;
            else if (w_clk_rise) r_sr <= w_sr_shifted;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.pad_data_o  = (bus.en && (r_state != IDLE)) ? r_sr[0] : 1'b1;
  assign bus.shift_cnt   = r_shift_cnt;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_abort = r_frame_abort;
  assign bus.frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_iob_nesctrl_pad.sv
// Directed + randomized bench for the NES pad emulator against a frame-level reference model.
module tb_iob_nesctrl_pad;
  localparam int   N    = 8;
  localparam logic FILL = 1'b0;

  logic clk = 1'b0;
  logic rst;

  iob_nesctrl_pad_if #(.N_BITS(N)) bus ();

  iob_nesctrl_pad #(.N_BITS(N), .FILL_VAL(FILL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_fail     = 0;
  int done_seen  = 0;
  int abort_seen = 0;

  // Reference model: latched buttons, shifts seen by the console, expected pulse totals.
  logic [N-1:0] m_btn;
  int           m_k;
  bit           m_active;
  int           m_done;
  int           m_abort;
  logic [15:0]  m_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) done_seen++;
    if (bus.frame_abort === 1'b1) abort_seen++;
    if (bus.frame_done === 1'b1 || bus.frame_abort === 1'b1)
      chk("pulse_exclusive", 32'(bus.frame_done & bus.frame_abort), 32'd0);
  end

  function automatic logic exp_bit(input logic [N-1:0] b, input int k);
    return (k < N) ? ~b[k] : FILL;
  endfunction

  function automatic int exp_cnt(input int k);
    return (k < N) ? k : N;
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic latch_load(input logic [N-1:0] b);
    if (m_active && m_k > 0 && m_k < N) m_abort++;
    bus.buttons     = b;
    bus.pad_latch_i = 1'b1;
    wait_n(6);
    bus.pad_latch_i = 1'b0;
    wait_n(6);
    m_btn    = b;
    m_k      = 0;
    m_active = 1'b1;
  endtask

  task automatic shift_one(input string tag);
    chk({tag, "_bit"}, 32'(bus.pad_data_o), 32'(exp_bit(m_btn, m_k)));
    bus.pad_clk_i = 1'b1;
    wait_n(6);
    bus.pad_clk_i = 1'b0;
    wait_n(6);
    m_k++;
    if (m_k == N) begin
      m_done++;
      m_fc++;
    end
    chk({tag, "_cnt"}, 32'(bus.shift_cnt), 32'(exp_cnt(m_k)));
  endtask

  task automatic totals_chk(input string tag);
    chk({tag, "_done"},  32'(done_seen),     32'(m_done));
    chk({tag, "_abort"}, 32'(abort_seen),    32'(m_abort));
    chk({tag, "_fcnt"},  32'(bus.frame_cnt), 32'(m_fc));
  endtask

  task automatic full_frame(input string tag, input logic [N-1:0] b);
    latch_load(b);
    for (int i = 0; i < N; i++) shift_one(tag);
    totals_chk(tag);
  endtask

  initial begin
    logic [31:0]  r32;
    logic [N-1:0] rb;

    m_btn = '0; m_k = 0; m_active = 1'b0; m_done = 0; m_abort = 0; m_fc = '0;
    rst             = 1'b1;
    bus.en          = 1'b1;
    bus.buttons     = '0;
    bus.pad_latch_i = 1'b0;
    bus.pad_clk_i   = 1'b1;
    wait_n(3);
    chk("rst_data", 32'(bus.pad_data_o), 32'd1);
    chk("rst_cnt",  32'(bus.shift_cnt),  32'd0);
    chk("rst_fcnt", 32'(bus.frame_cnt),  32'd0);

    // Clock line held high after reset, no latch: nothing may happen.
    rst = 1'b0;
    wait_n(10);
    chk("idle_data", 32'(bus.pad_data_o), 32'd1);
    chk("idle_cnt",  32'(bus.shift_cnt),  32'd0);
    totals_chk("idle");
    bus.pad_clk_i = 1'b0;
    wait_n(6);

    full_frame("f0101", 8'b0000_0101);
    for (int i = 0; i < 3; i++) shift_one("extra");
    chk("extra_data", 32'(bus.pad_data_o), 32'(FILL));
    totals_chk("extra");

    // Buttons change while latched: the last latched value wins.
    if (m_active && m_k > 0 && m_k < N) m_abort++;
    bus.buttons     = 8'h00;
    bus.pad_latch_i = 1'b1;
    wait_n(6);
    bus.buttons     = 8'hFF;
    wait_n(6);
    bus.pad_latch_i = 1'b0;
    wait_n(6);
    m_btn = 8'hFF; m_k = 0; m_active = 1'b1;
    chk("track_first", 32'(bus.pad_data_o), 32'd0);
    for (int i = 0; i < N; i++) shift_one("track");
    totals_chk("track");

    for (int f = 0; f < 4; f++) begin
      r32 = $urandom;
      rb  = r32[N-1:0];
      full_frame("rand", rb);
    end

    // Re-latch after 3 shifts aborts the frame.
    r32 = $urandom;
    latch_load(r32[N-1:0]);
    for (int i = 0; i < 3; i++) shift_one("pre_abort");
    r32 = $urandom;
    latch_load(r32[N-1:0]);
    chk("abort_cnt", 32'(bus.shift_cnt), 32'd0);
    totals_chk("abort");
    for (int i = 0; i < N; i++) shift_one("post_abort");
    totals_chk("post_abort");

    // Enable dropped after 4 shifts: frame discarded, line released.
    r32 = $urandom;
    latch_load(r32[N-1:0]);
    for (int i = 0; i < 4; i++) shift_one("pre_en");
    bus.en = 1'b0;
    wait_n(1);
    chk("en_off_data", 32'(bus.pad_data_o), 32'd1);
    wait_n(6);
    chk("en_off_cnt", 32'(bus.shift_cnt), 32'd4);
    totals_chk("en_off");
    m_active = 1'b0;
    bus.en = 1'b1;
    wait_n(2);
    r32 = $urandom;
    full_frame("re_en", r32[N-1:0]);

    // Reset mid-frame, then clock edges without a latch must not shift.
    r32 = $urandom;
    latch_load(r32[N-1:0]);
    for (int i = 0; i < 3; i++) shift_one("pre_rst");
    rst = 1'b1;
    wait_n(1);
    rst = 1'b0;
    m_active = 1'b0; m_k = 0; m_fc = '0;
    chk("mrst_data", 32'(bus.pad_data_o), 32'd1);
    chk("mrst_cnt",  32'(bus.shift_cnt),  32'd0);
    chk("mrst_fcnt", 32'(bus.frame_cnt),  32'd0);
    for (int i = 0; i < 2; i++) begin
      bus.pad_clk_i = 1'b1;
      wait_n(6);
      bus.pad_clk_i = 1'b0;
      wait_n(6);
    end
    chk("nolatch_cnt",  32'(bus.shift_cnt),  32'd0);
    chk("nolatch_data", 32'(bus.pad_data_o), 32'd1);
    r32 = $urandom;
    full_frame("post_rst", r32[N-1:0]);

    // Frame counter wrap from a preloaded value.
    force dut.r_frame_cnt = 16'hFFFE;
    wait_n(1);
    release dut.r_frame_cnt;
    m_fc = 16'hFFFE;
    wait_n(1);
    chk("preload_fcnt", 32'(bus.frame_cnt), 32'h0000FFFE);
    r32 = $urandom;
    full_frame("wrap1", r32[N-1:0]);
    r32 = $urandom;
    full_frame("wrap2", r32[N-1:0]);
    chk("wrap_zero", 32'(bus.frame_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/iob_nesctrl_pad.md
Name: iob_nesctrl_pad

Overview:
- Device-side emulation of an NES controller (HEF4021B-style parallel-in/serial-out), i.e. the responder to our NES controller host interface.
- Takes a button vector from the SoC and answers the console/host latch and clock lines with serial data on the Q7 line.
- Sits in the SoC fabric, with its pad pins routed to an NES port or looped back to the host interface for self-test.
- The console-side latch and clock are asynchronous. They are synchronized and edge-detected in the system clock domain.

Parameters:
- N_BITS, 8, number of button bits shifted per frame (range 2..16).
- FILL_VAL, 1'b0, electrical level driven on the data line after N_BITS shifts (the serial-input tie-off).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  block enable; 0 = pad idle.
- buttons  in  N_BITS  button state, 1 = pressed; bit 0 is shifted out first.
- pad_latch_i  in  1  console parallel-load (PL), active-high, asynchronous.
- pad_clk_i  in  1  console shift clock (CP), asynchronous; shifts on its rising edge.
- pad_data_o  out  1  serial data (Q7), active-low (0 = pressed).
- shift_cnt  out  $clog2(N_BITS+1)  shifts done in the current frame.
- frame_done  out  1  1-cycle pulse when the N_BITS-th shift completes.
- frame_abort  out  1  1-cycle pulse when a latch arrives mid-frame.
- frame_cnt  out  16  count of completed frames, wraps at 0xFFFF->0.

Behaviour:
- Synchronizers:
  - Each of pad_latch_i and pad_clk_i passes through 2 flops, which reset to 0, giving latch_s and clk_s.
  - clk_s_d is a 1-cycle delayed copy of clk_s; clk_rise = clk_s & ~clk_s_d.
  - The edge detector is evaluated only in SHIFT and DONE, so spurious edges after reset or in IDLE are ignored.
- Shift register sr[N_BITS-1:0] holds electrical levels.
  - pad_data_o = sr[0] when en=1 and state != IDLE; otherwise 1.
- Reset values:
  - state=IDLE, sr=all 1s, shift_cnt=0, frame_cnt=0, frame_done=0, frame_abort=0.
  - pad_data_o=1.
- FSM, priority top-down each cycle:
  - en=0 -> IDLE; sr, shift_cnt and frame_cnt hold; no pulses.
  - IDLE: latch_s=1 -> LOAD.
  - LOAD:
    - Every cycle: sr <= ~buttons, shift_cnt <= 0 (transparent load; button changes while latch is high are tracked).
    - latch_s=0 -> SHIFT; sr holds the last loaded value.
  - SHIFT:
    - latch_s=1 -> LOAD. If shift_cnt>0, pulse frame_abort. The latch beats a coincident clk_rise (the shift is dropped).
    - Else on clk_rise: sr <= {FILL_VAL, sr[N_BITS-1:1]}, shift_cnt++.
    - If the new shift_cnt==N_BITS -> DONE, with frame_done=1 and frame_cnt++ in the same cycle as the transition.
  - DONE:
    - clk_rise keeps shifting FILL_VAL in; shift_cnt saturates at N_BITS; no further pulses.
    - latch_s=1 -> LOAD; no abort.
- Latency: a pad edge reaches pad_data_o in 3 clk cycles (2 sync + 1 register). The console must hold each latch/clk phase for at least 4 clk cycles.
- frame_done and frame_abort are never asserted in the same cycle.
- Reset mid-frame: everything returns to reset values on the next edge; the next frame starts only from a fresh latch.
- en deasserted mid-frame: state -> IDLE, the frame is discarded without a pulse, and pad_data_o=1 from the next cycle.

Test Plan:
- Reset, then pad_clk_i held high with no latch -> pad_data_o=1, no shifts, shift_cnt=0, no pulses.
- buttons=8'b0000_0101, latch pulse, then 8 clk rising edges -> pad_data_o sequence before each edge = 0,1,0,1,1,1,1,1. frame_done pulses once at the 8th edge; frame_cnt=1; shift_cnt=8.
- Continue with 3 extra clk edges after the 8th -> pad_data_o=FILL_VAL=0, shift_cnt stays 8, no second frame_done.
- buttons changed from 8'h00 to 8'hFF while latch is high -> after latch falls, the first bit is 0 (pressed), reflecting the last value before latch fell.
- Latch re-asserted after 3 shifts -> frame_abort pulse, shift_cnt=0, frame_cnt unchanged; the following full frame returns bit 0 of buttons first.
- en dropped after 4 shifts -> pad_data_o=1 within 1 cycle, no frame_done. Re-enable, then latch + 8 clocks -> normal frame, frame_cnt increments by 1.
- frame_cnt preloaded near wrap via 65536 frames (or a forced value) -> wraps 0xFFFF -> 0x0000 on the next frame_done.
